// File: rtl/mult_div_pkg.sv
// Shared encodings and state type for the iterative multiply/divide unit.
package mult_div_pkg;

   localparam int MD_WIDTH      = 32;
   localparam int MD_ITERATIONS = MD_WIDTH;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_FIX,
      ST_DONE
   } md_state_t;

endpackage

// File: rtl/mult_div_sign_fix.sv
// Conditional two's-complement negation: the whole 2*WIDTH product, or the
// remainder (upper half) and quotient (lower half) independently.
module mult_div_sign_fix
   import mult_div_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic [2*WIDTH-1:0] value,
   input  logic               split,
   input  logic               neg_hi,
   input  logic               neg_lo,
   output logic [2*WIDTH-1:0] result
);

   always_comb begin
      result = value;
      if (split) begin
         if (neg_hi) result[2*WIDTH-1:WIDTH] = -value[2*WIDTH-1:WIDTH];
         if (neg_lo) result[WIDTH-1:0]       = -value[WIDTH-1:0];
      end else if (neg_lo) begin
         result = -value;
      end
   end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers (radix-2, one step per cycle).
// Divider datapath is built only when MULT_DIV_DIVIDE_EN is defined.
module mult_div_unit
   import mult_div_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   input  logic             HiWrite,
   input  logic             LoWrite,
   output logic             Busy,
   output logic             Done,
   output logic             DivByZero,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
);

   localparam int CNT_W = $clog2(WIDTH);

   md_state_t          state;
   logic [CNT_W-1:0]   count;
   logic [WIDTH-1:0]   opb;
   logic [2*WIDTH-1:0] acc;
   logic               is_div;
   logic               neg_hi;
   logic               neg_lo;

   logic               signed_op;
   logic               sign_diff;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [WIDTH:0]     add_sum;
   logic [2*WIDTH-1:0] step_next;
   logic [2*WIDTH-1:0] fixed;

   assign signed_op = (Op == OP_MULT) || (Op == OP_DIV);
   assign sign_diff = signed_op && (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
   assign mag_a     = (signed_op && SrcA[WIDTH-1]) ? -SrcA : SrcA;
   assign mag_b     = (signed_op && SrcB[WIDTH-1]) ? -SrcB : SrcB;

   // Multiply: acc = {partial, multiplier}; add multiplicand on lsb, shift right.
   assign add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);

`ifdef MULT_DIV_DIVIDE_EN
   logic [WIDTH:0]   shifted;
   logic             no_sub;
   logic [WIDTH-1:0] rem_next;

   // Divide: acc = {remainder, dividend/quotient}; restoring shift-subtract.
   assign shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
   assign no_sub   = shifted < {1'b0, opb};
   assign rem_next = no_sub ? shifted[WIDTH-1:0] : shifted[WIDTH-1:0] - opb;
`endif

   always_comb begin
      step_next = {add_sum, acc[WIDTH-1:1]};
`ifdef MULT_DIV_DIVIDE_EN
      if (is_div) step_next = {rem_next, acc[WIDTH-2:0], ~no_sub};
`endif
   end

   mult_div_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
      .value  (acc),
      .split  (is_div),
      .neg_hi (neg_hi),
      .neg_lo (neg_lo),
      .result (fixed)
   );

`ifdef MULT_DIV_DIVIDE_EN
   logic div_zero_q;
   assign DivByZero = div_zero_q;
`else
   assign DivByZero = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         count  <= '0;
         opb    <= '0;
         acc    <= '0;
         is_div <= 1'b0;
         neg_hi <= 1'b0;
         neg_lo <= 1'b0;
         Busy   <= 1'b0;
         Done   <= 1'b0;
         Hi     <= '0;
         Lo     <= '0;
`ifdef MULT_DIV_DIVIDE_EN
         div_zero_q <= 1'b0;
`endif
      end else begin
         Done <= 1'b0;
`ifdef MULT_DIV_DIVIDE_EN
         div_zero_q <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
               if (Start) begin
                  count  <= '0;
                  opb    <= mag_b;
                  acc    <= {{WIDTH{1'b0}}, mag_a};
                  is_div <= Op[1];
                  neg_lo <= sign_diff;
                  neg_hi <= Op[1] ? (signed_op && SrcA[WIDTH-1]) : sign_diff;
                  if (Op[1]) begin
`ifdef MULT_DIV_DIVIDE_EN
                     if (SrcB == '0) begin
                        state      <= ST_DONE;
                        Done       <= 1'b1;
                        div_zero_q <= 1'b1;
                     end else begin
                        state <= ST_RUN;
                        Busy  <= 1'b1;
                     end
`else
                     state <= ST_DONE;
                     Done  <= 1'b1;
`endif
                  end else begin
                     state <= ST_RUN;
                     Busy  <= 1'b1;
                  end
               end else begin
                  if (HiWrite) Hi <= SrcA;
                  if (LoWrite) Lo <= SrcA;
               end
            end
            ST_RUN: begin
               acc   <= step_next;
               count <= count + 1'b1;
               if (count == CNT_W'(WIDTH-1)) state <= ST_FIX;
            end
            ST_FIX: begin
               Hi    <= fixed[2*WIDTH-1:WIDTH];
               Lo    <= fixed[WIDTH-1:0];
               Busy  <= 1'b0;
               Done  <= 1'b1;
               state <= ST_DONE;
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
